rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Parametrised RV32I instruction decode stage, successor to the single-format R-type decoder.
- Decodes all base formats (R/I/S/B/U/J) and generates sign-extended immediates.
- Carries the PC alongside each instruction; sits between fetch and register-read.
- Valid/ready handshake on both sides; 2-entry skid buffer gives full throughput with registered outputs; keeps statistics counters.

Parameters:
- XLEN, 32: immediate width, must be >= 32; immediates sign-extended to XLEN.
- PC_W, 32: width of in_pc/out_pc.
- SUPPORT_M, 1: if 1, R-type funct7=0000001 is legal (M extension).
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals !skid_valid (registered).
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of the decoded instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12] for R/I/S/B; else 0.
- funct7  out  7  instr[31:25] for R; else 0.
- rs1  out  5  instr[19:15] for R/I/S/B; else 0.
- rs2  out  5  instr[24:20] for R/S/B; else 0.
- rd  out  5  instr[11:7] for R/I/U/J; else 0.
- imm  out  XLEN  sign-extended immediate; 0 for R and illegal.
- fmt  out  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- illegal  out  1  unsupported opcode or R-type funct7.
- insn_count  out  CNT_W  saturating count of output handshakes.
- illegal_count  out  CNT_W  saturating count of output handshakes with illegal=1.

Behaviour:
- reset=0 at a clock edge: out_valid=0, skid_valid=0, in_ready=1. All payload outputs (out_pc, opcode, funct3, funct7, rs1, rs2, rd, imm) are 0. fmt=0, illegal=0, both counters 0. Reset overrides flush and all handshakes.
- Opcode map:
  - 0110011 -> R.
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - Any other opcode -> fmt=7, illegal=1.
- R-type funct7 must be 0000000 or 0100000, or 0000001 when SUPPORT_M=1. Any other funct7 gives fmt=0 with illegal=1.
- For illegal instructions, opcode is still passed through; all other fields and imm are 0.
- Immediates are sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Decode is combinational on the input; results are registered. Latency is 1 cycle from the accept edge to out_valid.
- Storage is an output register plus one skid register. Occupancy states: EMPTY (out_valid=0), ONE (out_valid=1, skid empty), FULL (both valid).
- accept = in_valid & in_ready. drain = out_valid & out_ready.
- EMPTY:
  - accept -> ONE.
- ONE:
  - accept & drain -> ONE, with the new data in the output register.
  - accept & !drain -> FULL, with the new data in skid.
  - !accept & drain -> EMPTY.
- FULL (in_ready=0):
  - drain -> ONE, with skid moving to the output register.
- Order is strictly preserved. Output payload is held stable while out_valid & !out_ready.
- flush=1: next state is EMPTY and in_ready=1. Any beat accepted in the same cycle is discarded. Counters are not affected by flush, except that a drain occurring in that cycle is still counted.
- Counters increment on drain and saturate at 2^CNT_W-1, with no wrap.

Test Plan:
- Reset held 2 cycles, then released: all outputs 0, in_ready=1. Send 0x00C58533 (add x10,x11,x12) with out_ready=1 -> next cycle out_valid=1, fmt=0, rd=10, rs1=11, rs2=12, funct7=0, imm=0, insn_count=1 after drain.
- Immediates:
  - 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFFFFF, fmt=1.
  - 0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC, fmt=2, rd=0.
  - 0xFE000EE3 (beq, -4) -> imm=0xFFFFFFFC, fmt=3.
  - 0x123450B7 (lui) -> imm=0x12345000.
  - 0x0080006F (jal +8) -> imm=8, fmt=5.
- Backpressure: out_ready=0 while streaming 3 instructions -> first two held (FULL), in_ready=0, third waits. Raise out_ready -> all three emerge in order, one per cycle.
- Illegal inputs: 0x0000007F -> fmt=7, illegal=1, illegal_count=1. 0x02C58533 (mul) with SUPPORT_M=0 -> illegal=1; with SUPPORT_M=1 -> legal R.
- Flush and reset mid-operation: assert flush while FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged. Reset while FULL -> all outputs and counters 0.
- Saturation with CNT_W=2: drain 5 instructions -> insn_count=3.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes all base formats (R/I/S/B/U/J), sign-extends
// immediates to XLEN and carries the PC alongside each instruction.
// A 2-entry store (output register plus skid register) gives full throughput
// with registered outputs. Saturating counters track handshakes and illegals.
module rv_decode_stage #(
  parameter int XLEN      = 32,
  parameter int PC_W      = 32,
  parameter int SUPPORT_M = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Full decode of one instruction word; unused fields are forced to zero.
  function automatic payload_t decode(input logic [31:0] instr, input logic [PC_W-1:0] pc);
    payload_t         p;
    logic signed [31:0] imm32;
    logic             f7_ok;
    p        = '0;
    imm32    = '0;
    p.pc     = pc;
    p.opcode = instr[6:0];
    f7_ok    = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000) ||
               ((SUPPORT_M != 0) && (instr[31:25] == 7'b0000001));
    case (instr[6:0])
      OP_R: begin
        p.fmt = FMT_R;
        if (f7_ok) begin
          p.funct3 = instr[14:12];
          p.funct7 = instr[31:25];
          p.rs1    = instr[19:15];
          p.rs2    = instr[24:20];
          p.rd     = instr[11:7];
        end else begin
          p.illegal = 1'b1;
        end
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        p.fmt    = FMT_I;
        p.funct3 = instr[14:12];
        p.rs1    = instr[19:15];
        p.rd     = instr[11:7];
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        p.fmt    = FMT_S;
        p.funct3 = instr[14:12];
        p.rs1    = instr[19:15];
        p.rs2    = instr[24:20];
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        p.fmt    = FMT_B;
        p.funct3 = instr[14:12];
        p.rs1    = instr[19:15];
        p.rs2    = instr[24:20];
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        p.fmt = FMT_U;
        p.rd  = instr[11:7];
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        p.fmt = FMT_J;
        p.rd  = instr[11:7];
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        p.fmt     = FMT_ILL;
        p.illegal = 1'b1;
      end
    endcase
    p.imm = XLEN'(imm32);
    return p;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e     state_q, state_d;
  payload_t   out_q, skid_q, dec;
  logic       accept, drain;
  logic       load_out, load_skid, out_from_skid;
  logic [CNT_W-1:0] insn_cnt_q, ill_cnt_q;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign dec       = decode(in_instr, in_pc);

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and which storage register captures data this cycle.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d       = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
    end
  end

  // Output and skid payload registers; output holds while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  // Statistics: count every output handshake, including one during flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      insn_cnt_q <= '0;
      ill_cnt_q  <= '0;
    end else if (drain) begin
      insn_cnt_q <= sat_inc(insn_cnt_q);
      if (out_q.illegal) ill_cnt_q <= sat_inc(ill_cnt_q);
    end
  end

  assign out_pc        = out_q.pc;
  assign opcode        = out_q.opcode;
  assign funct3        = out_q.funct3;
  assign funct7        = out_q.funct7;
  assign rs1           = out_q.rs1;
  assign rs2           = out_q.rs2;
  assign rd            = out_q.rd;
  assign imm           = out_q.imm;
  assign fmt           = out_q.fmt;
  assign illegal       = out_q.illegal;
  assign insn_count    = insn_cnt_q;
  assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Testbench for rv_decode_stage: two instances share one stimulus stream,
// A with SUPPORT_M=1/CNT_W=16 and B with SUPPORT_M=0/CNT_W=2.
module tb_rv_decode_stage;

  logic        clk, reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3, a_fmt;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [15:0] a_insn_count, a_illegal_count;

  logic        b_in_ready, b_out_valid, b_illegal;
  logic [31:0] b_out_pc, b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3, b_fmt;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_insn_count, b_illegal_count;

  rv_decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .imm(a_imm), .fmt(a_fmt), .illegal(a_illegal),
    .insn_count(a_insn_count), .illegal_count(a_illegal_count)
  );

  rv_decode_stage #(.XLEN(32), .PC_W(32), .SUPPORT_M(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .imm(b_imm), .fmt(b_fmt), .illegal(b_illegal),
    .insn_count(b_insn_count), .illegal_count(b_illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  beat_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    cnt = 0;
  int    ill_a = 0;
  int    ill_b = 0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference decode built from masks and shifts of the raw word.
  function automatic dec_t model(input logic [31:0] w, input bit m);
    dec_t        d;
    logic [31:0] sgn;
    d        = '0;
    d.opcode = w[6:0];
    sgn      = w[31] ? 32'hFFFF_FFFF : 32'h0;
    case (w[6:0])
      7'h33: begin
        d.fmt = 3'd0;
        if (!(w[31:25] == 7'h00 || w[31:25] == 7'h20 || (m && w[31:25] == 7'h01))) d.ill = 1'b1;
      end
      7'h13, 7'h03, 7'h67: d.fmt = 3'd1;
      7'h23:               d.fmt = 3'd2;
      7'h63:               d.fmt = 3'd3;
      7'h37, 7'h17:        d.fmt = 3'd4;
      7'h6F:               d.fmt = 3'd5;
      default: begin d.fmt = 3'd7; d.ill = 1'b1; end
    endcase
    if (!d.ill) begin
      if (d.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) begin d.rs1 = w[19:15]; d.f3 = w[14:12]; end
      if (d.fmt inside {3'd0, 3'd2, 3'd3}) d.rs2 = w[24:20];
      if (d.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) d.rd = w[11:7];
      if (d.fmt == 3'd0) d.f7 = w[31:25];
      case (d.fmt)
        3'd1: d.imm = (sgn & 32'hFFFF_F000) | (w >> 20);
        3'd2: d.imm = (sgn & 32'hFFFF_F000) | ((w >> 20) & 32'hFE0) | ((w >> 7) & 32'h1F);
        3'd3: d.imm = (sgn & 32'hFFFF_F000) | ((w << 4) & 32'h800) | ((w >> 20) & 32'h7E0) |
                      ((w >> 7) & 32'h1E);
        3'd4: d.imm = w & 32'hFFFF_F000;
        3'd5: d.imm = (sgn & 32'hFFF0_0000) | (w & 32'h000F_F000) | ((w >> 9) & 32'h800) |
                      ((w >> 20) & 32'h7FE);
        default: d.imm = 32'h0;
      endcase
    end
    return d;
  endfunction

  function automatic dec_t obs_a();
    return '{opcode: a_opcode, f3: a_funct3, f7: a_funct7, rs1: a_rs1, rs2: a_rs2,
             rd: a_rd, imm: a_imm, fmt: a_fmt, ill: a_illegal};
  endfunction

  function automatic dec_t obs_b();
    return '{opcode: b_opcode, f3: b_funct3, f7: b_funct7, rs1: b_rs1, rs2: b_rs2,
             rd: b_rd, imm: b_imm, fmt: b_fmt, ill: b_illegal};
  endfunction

  // One clock: score the handshakes about to happen, advance, then check state.
  task automatic cycle();
    bit    acc, drn;
    beat_t b;
    dec_t  ea, eb;
    acc = in_valid && a_in_ready;
    drn = a_out_valid && out_ready;
    if (!reset) begin
      q.delete();
      cnt = 0; ill_a = 0; ill_b = 0;
    end else begin
      if (drn) begin
        if (q.size() == 0) begin
          check("sb_underflow", 128'd1, 128'd0);
        end else begin
          b  = q.pop_front();
          ea = model(b.instr, 1'b1);
          eb = model(b.instr, 1'b0);
          check("a_decode", obs_a(), ea);
          check("b_decode", obs_b(), eb);
          check("a_pc", a_out_pc, b.pc);
          check("b_pc", b_out_pc, b.pc);
          cnt++;
          if (ea.ill) ill_a++;
          if (eb.ill) ill_b++;
        end
      end
      if (flush) q.delete();
      else if (acc) begin
        b.instr = in_instr;
        b.pc    = in_pc;
        q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    check("a_in_ready", a_in_ready, q.size() < 2);
    check("b_in_ready", b_in_ready, q.size() < 2);
    check("a_out_valid", a_out_valid, q.size() > 0);
    check("b_out_valid", b_out_valid, q.size() > 0);
    check("a_insn_count", a_insn_count, (cnt > 65535) ? 65535 : cnt);
    check("a_illegal_count", a_illegal_count, (ill_a > 65535) ? 65535 : ill_a);
    check("b_insn_count", b_insn_count, (cnt > 3) ? 3 : cnt);
    check("b_illegal_count", b_illegal_count, (ill_b > 3) ? 3 : ill_b);
  endtask

  task automatic push_beat(input logic [31:0] instr, input logic [31:0] pc);
    bit ok;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = a_in_ready;
      cycle();
    end
    if (!ok) check("push_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_imm(input string name, input logic [31:0] instr,
                          input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
    out_ready = 1'b0;
    push_beat(instr, 32'h200);
    check({name, "_imm"}, a_imm, exp_imm);
    check({name, "_fmt"}, a_fmt, exp_fmt);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a_payload"}, {a_out_pc, obs_a()}, 128'd0);
    check({name, "_b_payload"}, {b_out_pc, obs_b()}, 128'd0);
    check({name, "_a_ctl"}, {a_out_valid, a_in_ready, a_insn_count, a_illegal_count}, {2'b01, 32'd0});
    check({name, "_b_ctl"}, {b_out_valid, b_in_ready, b_insn_count, b_illegal_count}, {2'b01, 4'd0});
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;

    // Reset held for two cycles.
    cycle();
    cycle();
    check_all_zero("reset");
    reset = 1'b1;

    // add x10,x11,x12
    out_ready = 1'b1;
    push_beat(32'h00C58533, 32'h100);
    check("add_fields", {a_fmt, a_rd, a_rs1, a_rs2, a_funct7, a_imm},
          {3'd0, 5'd10, 5'd11, 5'd12, 7'd0, 32'd0});
    cycle();
    check("add_count", a_insn_count, 16'd1);
    out_ready = 1'b0;

    // Immediate formats.
    send_imm("addi", 32'hFFF00093, 32'hFFFF_FFFF, 3'd1);
    send_imm("sw",   32'hFE112E23, 32'hFFFF_FFFC, 3'd2);
    send_imm("beq",  32'hFE000EE3, 32'hFFFF_FFFC, 3'd3);
    send_imm("lui",  32'h123450B7, 32'h1234_5000, 3'd4);
    send_imm("jal",  32'h0080006F, 32'h0000_0008, 3'd5);

    // Backpressure: three beats offered while the output is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr = 32'h40B50533; in_pc = 32'h300; cycle();
    in_instr = 32'h00452283; in_pc = 32'h304; cycle();
    in_instr = 32'h00000517; in_pc = 32'h308; cycle();
    check("bp_full", {a_in_ready, a_out_valid, a_opcode}, {1'b0, 1'b1, 7'h33});
    out_ready = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    check("bp_drained", a_out_valid, 1'b0);

    // Illegal opcode and the M-extension funct7.
    send_imm("ill7f", 32'h0000007F, 32'h0, 3'd7);
    out_ready = 1'b0;
    push_beat(32'h02C58533, 32'h400);
    check("mul_legal_a", {a_illegal, a_fmt, a_funct7}, {1'b0, 3'd0, 7'h01});
    check("mul_illegal_b", {b_illegal, b_fmt, b_funct7, b_rd}, {1'b1, 3'd0, 7'h00, 5'd0});
    out_ready = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) push_beat(32'h0000007F + (i << 20), 32'h500 + i * 4);
    cycle();

    // Flush while FULL with a beat offered.
    out_ready = 1'b0;
    push_beat(32'h00100093, 32'h600);
    push_beat(32'h00200113, 32'h604);
    in_valid = 1'b1; in_instr = 32'h00300193; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full", {a_out_valid, a_in_ready}, 2'b01);

    // Flush in ONE with simultaneous accept and drain.
    push_beat(32'h00400213, 32'h700);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500293; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_one", {a_out_valid, a_in_ready}, 2'b01);

    // Reset while FULL.
    out_ready = 1'b0;
    push_beat(32'h00600313, 32'h800);
    push_beat(32'h00700393, 32'h804);
    reset = 1'b0;
    cycle();
    check_all_zero("reset_full");
    reset = 1'b1;
    cycle();

    // Random traffic with random backpressure.
    for (int c = 0; c < 60; c++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_instr  = (c % 3 == 0) ? $urandom() : {$urandom_range(0, 32'hFFFFFF), 1'b0, 7'h13};
      in_pc     = 32'h1000 + c * 4;
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
    check("final_empty", a_out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
